// File: rtl/serial_neuron_layer.sv
// Time-multiplexed fully-connected layer with step activation using one shared MAC.
// Optional NN_SATURATE_EN: saturating product and accumulator instead of truncate/wrap.
module serial_neuron_layer #(
  parameter int DATA_WIDTH   = 16,
  parameter int INPUT_SIZE   = 8,
  parameter int NEURON_COUNT = 4
) (
  input  logic                                             clock,
  input  logic                                             reset,
  input  logic                                             start,
  input  logic [DATA_WIDTH*INPUT_SIZE-1:0]                 input_data,
  input  logic [DATA_WIDTH*NEURON_COUNT*(INPUT_SIZE+1)-1:0] weights,
  output logic                                             busy,
  output logic                                             done,
  output logic [DATA_WIDTH*NEURON_COUNT-1:0]               output_data
);

  localparam int W    = DATA_WIDTH;
  localparam int FRAC = W / 2;
  localparam int IW   = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
  localparam int NW   = (NEURON_COUNT > 1) ? $clog2(NEURON_COUNT) : 1;
  localparam logic [W-1:0]  ONE    = {{(W-1){1'b0}}, 1'b1} << FRAC;
  localparam logic [IW-1:0] I_LAST = IW'(INPUT_SIZE - 1);
  localparam logic [NW-1:0] N_LAST = NW'(NEURON_COUNT - 1);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_ACT, S_DONE} state_t;

  state_t                      state_q;
  logic [W*INPUT_SIZE-1:0]     in_q;
  logic [W-1:0]                acc_q;
  logic [IW-1:0]               i_q;
  logic [NW-1:0]               n_q;
  logic [W*NEURON_COUNT-1:0]   res_q;
  logic [W*NEURON_COUNT-1:0]   out_q;
  logic                        busy_q;
  logic                        done_q;

  int unsigned                 in_idx;
  int unsigned                 w_idx;
  int unsigned                 thr_idx;
  int unsigned                 res_idx;
  logic [W-1:0]                op_in;
  logic [W-1:0]                op_w;
  logic [W-1:0]                thr;
  logic [2*W-1:0]              prod_full;
  logic [FRAC-1:0]             prod_frac_unused;
  logic [W-1:0]                prod_lo;
  logic [W-1:0]                prod_d;
  logic [W-1:0]                acc_d;
  logic [W-1:0]                act_d;
  logic [W*NEURON_COUNT-1:0]   res_d;
`ifdef NN_SATURATE_EN
  logic [W-FRAC-1:0]           prod_hi;
  logic [W:0]                  sum_full;
`else
  logic [W-FRAC-1:0]           prod_hi_unused;
`endif

  always_comb begin
    in_idx  = 32'(i_q);
    w_idx   = 32'(n_q) * (INPUT_SIZE + 1) + 32'(i_q);
    thr_idx = 32'(n_q) * (INPUT_SIZE + 1) + INPUT_SIZE;
    res_idx = 32'(n_q);
    op_in   = in_q[in_idx*W +: W];
    op_w    = weights[w_idx*W +: W];
    thr     = weights[thr_idx*W +: W];
    prod_full = {{W{1'b0}}, op_in} * {{W{1'b0}}, op_w};
`ifdef NN_SATURATE_EN
    {prod_hi, prod_lo, prod_frac_unused} = prod_full;
    prod_d   = (|prod_hi) ? '1 : prod_lo;
    sum_full = {1'b0, acc_q} + {1'b0, prod_d};
    acc_d    = sum_full[W] ? '1 : sum_full[W-1:0];
`else
    {prod_hi_unused, prod_lo, prod_frac_unused} = prod_full;
    prod_d = prod_lo;
    acc_d  = acc_q + prod_d;
`endif
    act_d = (acc_q >= thr) ? ONE : '0;
    res_d = res_q;
    res_d[res_idx*W +: W] = act_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      in_q    <= '0;
      acc_q   <= '0;
      i_q     <= '0;
      n_q     <= '0;
      res_q   <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        // DONE doubles as an accept slot so a held start issues every N*(I+1)+1 cycles
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            in_q    <= input_data;
            acc_q   <= '0;
            i_q     <= '0;
            n_q     <= '0;
            busy_q  <= 1'b1;
            state_q <= S_MAC;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_MAC: begin
          acc_q <= acc_d;
          if (i_q == I_LAST) begin
            i_q     <= '0;
            state_q <= S_ACT;
          end else begin
            i_q <= i_q + 1'b1;
          end
        end
        S_ACT: begin
          res_q <= res_d;
          acc_q <= '0;
          i_q   <= '0;
          if (n_q == N_LAST) begin
            out_q   <= res_d;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            n_q     <= n_q + 1'b1;
            state_q <= S_MAC;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign output_data = out_q;

endmodule

// File: tb/tb_serial_neuron_layer.sv
// Directed bench for serial_neuron_layer: W=16,I=2,N=2 instance plus an I=1,N=1 instance.
module tb_serial_neuron_layer;

`ifdef NN_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a, start_b;
  logic [31:0] in_a;
  logic [95:0] w_a;
  logic        busy_a, done_a;
  logic [31:0] out_a;
  logic [15:0] in_b;
  logic [31:0] w_b;
  logic        busy_b, done_b;
  logic [15:0] out_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_neuron_layer #(.DATA_WIDTH(16), .INPUT_SIZE(2), .NEURON_COUNT(2)) dut_a (
    .clock(clk), .reset(rst), .start(start_a), .input_data(in_a), .weights(w_a),
    .busy(busy_a), .done(done_a), .output_data(out_a)
  );

  serial_neuron_layer #(.DATA_WIDTH(16), .INPUT_SIZE(1), .NEURON_COUNT(1)) dut_b (
    .clock(clk), .reset(rst), .start(start_b), .input_data(in_b), .weights(w_b),
    .busy(busy_b), .done(done_b), .output_data(out_b)
  );

  typedef struct {
    logic [15:0] in0, in1;
    logic [15:0] w00, w01, t0;
    logic [15:0] w10, w11, t1;
    logic [15:0] e0, e1;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [95:0] pack_w(input vec_t v);
    return {v.t1, v.w11, v.w10, v.t0, v.w01, v.w00};
  endfunction

  // Issue one run on dut_a; lat = edges from accept to done, bc = busy cycles before done.
  task automatic run_a(input logic [31:0] ind, input logic [95:0] wts, output int lat, output int bc);
    @(negedge clk);
    in_a = ind; w_a = wts; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    lat = 0;
    bc = busy_a ? 1 : 0;
    while (!done_a && lat < 50) begin
      @(negedge clk);
      lat++;
      if (busy_a && !done_a) bc++;
    end
  endtask

  initial begin
    int lat, bc, k, nd;
    int dk[3];
    logic [31:0] prev;

    vecs[0] = '{16'h0100, 16'h0200, 16'h0080, 16'h0080, 16'h0180, 16'h0080, 16'h0080, 16'h0181,
                16'h0100, 16'h0000};
    vecs[1] = '{16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00, 16'hFFFF, 16'hFF00, 16'hFF00, 16'h0200,
                SAT ? 16'h0100 : 16'h0000, 16'h0100};
    vecs[2] = '{16'h0000, 16'h0000, 16'h1111, 16'h1111, 16'h0000, 16'h1111, 16'h1111, 16'h0001,
                16'h0100, 16'h0000};
    vecs[3] = '{16'h0300, 16'h0040, 16'h0200, 16'h0400, 16'h0700, 16'h0001, 16'h0001, 16'h0004,
                16'h0100, 16'h0000};
    vecs[4] = '{16'h8000, 16'h8000, 16'h0200, 16'h0000, 16'h0001, 16'h0100, 16'h0100, 16'h0001,
                SAT ? 16'h0100 : 16'h0000, SAT ? 16'h0100 : 16'h0000};
    vecs[5] = '{16'h8000, 16'h8000, 16'h0100, 16'h0080, 16'hC000, 16'h0100, 16'h0080, 16'hC001,
                16'h0100, 16'h0000};

    rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
    in_a = '0; w_a = '0; in_b = '0; w_b = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", {31'b0, busy_a}, 32'd0);
    chk("reset_done", {31'b0, done_a}, 32'd0);
    chk("reset_out", out_a, 32'h0);
    rst = 1'b0;

    for (int v = 0; v < 6; v++) begin
      run_a({vecs[v].in1, vecs[v].in0}, pack_w(vecs[v]), lat, bc);
      chk($sformatf("vec%0d_latency", v), lat, 32'd6);
      chk($sformatf("vec%0d_busy_cycles", v), bc, 32'd6);
      chk($sformatf("vec%0d_out0", v), {16'h0, out_a[15:0]}, {16'h0, vecs[v].e0});
      chk($sformatf("vec%0d_out1", v), {16'h0, out_a[31:16]}, {16'h0, vecs[v].e1});
      @(negedge clk);
      chk($sformatf("vec%0d_done_pulse", v), {31'b0, done_a}, 32'd0);
    end

    // input_data changed after accept; output holds previous result through the run
    run_a({vecs[1].in1, vecs[1].in0}, pack_w(vecs[1]), lat, bc);
    prev = {vecs[1].e1, vecs[1].e0};
    @(negedge clk);
    in_a = {vecs[0].in1, vecs[0].in0}; w_a = pack_w(vecs[0]); start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    in_a = {16'h0040, 16'h0300};
    @(negedge clk);
    chk("capture_hold_out", out_a, prev);
    lat = 1;
    while (!done_a && lat < 50) begin @(negedge clk); lat++; end
    chk("capture_latency", lat, 32'd6);
    chk("capture_result", out_a, {vecs[0].e1, vecs[0].e0});

    // start held high: back-to-back runs, one done every 7 cycles
    @(negedge clk);
    in_a = {vecs[0].in1, vecs[0].in0}; w_a = pack_w(vecs[0]); start_a = 1'b1;
    nd = 0;
    for (k = 0; k <= 20; k++) begin
      @(negedge clk);
      if (done_a) begin
        if (nd < 3) dk[nd] = k;
        nd++;
      end
    end
    start_a = 1'b0;
    chk("b2b_done_count", nd, 32'd3);
    chk("b2b_done0", dk[0], 32'd6);
    chk("b2b_done1", dk[1], 32'd13);
    chk("b2b_done2", dk[2], 32'd20);
    chk("b2b_result", out_a, {vecs[0].e1, vecs[0].e0});
    @(negedge clk);
    chk("b2b_idle_busy", {31'b0, busy_a}, 32'd0);

    // reset during the 3rd busy cycle aborts the run
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midreset_busy_before", {31'b0, busy_a}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midreset_busy", {31'b0, busy_a}, 32'd0);
    chk("midreset_done", {31'b0, done_a}, 32'd0);
    chk("midreset_out", out_a, 32'h0);
    nd = 0;
    repeat (10) begin @(negedge clk); if (done_a || busy_a) nd++; end
    chk("midreset_quiet", nd, 32'd0);
    run_a({vecs[3].in1, vecs[3].in0}, pack_w(vecs[3]), lat, bc);
    chk("postreset_latency", lat, 32'd6);
    chk("postreset_result", out_a, {vecs[3].e1, vecs[3].e0});

    // I=1,N=1: zero sum against zero threshold hits the >= boundary
    @(negedge clk);
    in_b = 16'h0000; w_b = {16'h0000, 16'h1234}; start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    lat = 0;
    while (!done_b && lat < 50) begin @(negedge clk); lat++; end
    chk("small_latency", lat, 32'd2);
    chk("small_out", {16'h0, out_b}, 32'h0100);
    @(negedge clk);
    chk("small_done_pulse", {31'b0, done_b}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
